wb_stage_pipe: RTL and testbench

//  Registered MEM/WB boundary and writeback-data selection for the MIPS pipeline. Captures MEM-stage results

---
 rtl/wb_stage_pipe_pkg.sv | 34 +++
 rtl/wb_stage_pipe_load_align.sv | 55 +++++
 rtl/wb_stage_pipe.sv | 124 ++++++++++++
 tb/tb_wb_stage_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pipe_pkg.sv
// Shared encodings and defaults for the MEM/WB writeback stage.
package wb_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int RADDR_W_DEF = 5;

   // Writeback source select; the reserved code falls back to the ALU path.
   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'd0,
      WB_SEL_MEM  = 2'd1,
      WB_SEL_LINK = 2'd2,
      WB_SEL_RSVD = 2'd3
   } wb_sel_e;

   // Load width/sign encodings; unlisted codes behave as a full word load.
   typedef enum logic [2:0] {
      LD_LW  = 3'd0,
      LD_LB  = 3'd1,
      LD_LBU = 3'd2,
      LD_LH  = 3'd3,
      LD_LHU = 3'd4
   } load_type_e;

   // Extend an 8-bit lane to 32 bits, signed or unsigned.
   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
      ext_byte = {{24{sgn & b[7]}}, b};
   endfunction

   // Extend a 16-bit lane to 32 bits, signed or unsigned.
   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
      ext_half = {{16{sgn & h[15]}}, h};
   endfunction

endpackage

// File: rtl/wb_stage_pipe_load_align.sv
// Combinational little-endian sub-word alignment and misalignment detection.
module load_align
   import wb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic [2:0]        load_type_i,
   input  logic [1:0]        byte_off_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              misalign_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte lane and half lane from the raw word.
   always_comb begin
      byte_s = mem_rdata_i[{byte_off_i, 3'b000} +: 8];
      if (byte_off_i[1]) begin
         half_s = mem_rdata_i[31:16];
      end else begin
         half_s = mem_rdata_i[15:0];
      end
   end

   // Extend the selected lane and flag accesses that break natural alignment.
   always_comb begin
      rdata_o    = mem_rdata_i;
      misalign_o = 1'b0;
      case (load_type_i)
         LD_LB: begin
            rdata_o    = ext_byte(byte_s, 1'b1);
            misalign_o = 1'b0;
         end
         LD_LBU: begin
            rdata_o    = ext_byte(byte_s, 1'b0);
            misalign_o = 1'b0;
         end
         LD_LH: begin
            rdata_o    = ext_half(half_s, 1'b1);
            misalign_o = byte_off_i[0];
         end
         LD_LHU: begin
            rdata_o    = ext_half(half_s, 1'b0);
            misalign_o = byte_off_i[0];
         end
         default: begin
            rdata_o    = mem_rdata_i;
            misalign_o = (byte_off_i != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register: writeback source mux, load alignment, retire counter.
module wb_stage_pipe
   import wb_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int RADDR_W = RADDR_W_DEF,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_wb,
   input  logic               flush_wb,
   input  logic               valid_mem,
   input  logic               wreg_mem,
   input  logic [1:0]         wb_sel_mem,
   input  logic [2:0]         load_type_mem,
   input  logic [1:0]         byte_off_mem,
   input  logic [DATA_W-1:0]  mem_rdata_mem,
   input  logic [DATA_W-1:0]  alu_result_mem,
   input  logic [DATA_W-1:0]  link_pc_mem,
   input  logic [RADDR_W-1:0] wt_addr_mem,
   output logic               wreg_wb,
   output logic [RADDR_W-1:0] wt_addr_wb,
   output logic [DATA_W-1:0]  wt_data_wb,
   output logic               valid_wb,
   output logic               misalign_wb,
   output logic [CNT_W-1:0]   retired_cnt
);

   logic [DATA_W-1:0]  aligned_s;
   logic               align_mis_s;
   logic [DATA_W-1:0]  sel_data_s;
   logic               misalign_s;

   logic               valid_q,    valid_d;
   logic               wreg_q,     wreg_d;
   logic [RADDR_W-1:0] addr_q,     addr_d;
   logic [DATA_W-1:0]  data_q,     data_d;
   logic               misalign_q, misalign_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;

   load_align #(
      .DATA_W (DATA_W)
   ) u_load_align (
      .mem_rdata_i (mem_rdata_mem),
      .load_type_i (load_type_mem),
      .byte_off_i  (byte_off_mem),
      .rdata_o     (aligned_s),
      .misalign_o  (align_mis_s)
   );

   // Writeback source mux; misalignment only matters for real memory-sourced writebacks.
   always_comb begin
      case (wb_sel_mem)
         WB_SEL_MEM:  sel_data_s = aligned_s;
         WB_SEL_LINK: sel_data_s = link_pc_mem;
         default:     sel_data_s = alu_result_mem;
      endcase
      if (valid_mem && (wb_sel_mem == WB_SEL_MEM)) begin
         misalign_s = align_mis_s;
      end else begin
         misalign_s = 1'b0;
      end
   end

   // Next-state for the WB register: flush beats stall beats load.
   always_comb begin
      if (flush_wb) begin
         valid_d    = 1'b0;
         wreg_d     = 1'b0;
         addr_d     = {RADDR_W{1'b0}};
         data_d     = {DATA_W{1'b0}};
         misalign_d = 1'b0;
      end else if (stall_wb) begin
         valid_d    = valid_q;
         wreg_d     = wreg_q;
         addr_d     = addr_q;
         data_d     = data_q;
         misalign_d = misalign_q;
      end else begin
         valid_d    = valid_mem;
         wreg_d     = wreg_mem & valid_mem & (wt_addr_mem != {RADDR_W{1'b0}}) & ~misalign_s;
         addr_d     = wt_addr_mem;
         data_d     = sel_data_s;
         misalign_d = misalign_s;
      end
   end

   // Retire counter: the instruction in WB retires on any non-stalled edge, wrapping freely.
   always_comb begin
      if (valid_q && !stall_wb) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous reset taking precedence over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         wreg_q     <= 1'b0;
         addr_q     <= {RADDR_W{1'b0}};
         data_q     <= {DATA_W{1'b0}};
         misalign_q <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
      end else begin
         valid_q    <= valid_d;
         wreg_q     <= wreg_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign valid_wb    = valid_q;
   assign wreg_wb     = wreg_q;
   assign wt_addr_wb  = addr_q;
   assign wt_data_wb  = data_q;
   assign misalign_wb = misalign_q;
   assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench for wb_stage_pipe with a narrow retire counter to exercise wrap.
module tb_wb_stage_pipe;

   localparam int CW = 4;

   logic        clk = 1'b0;
   logic        rst, stall_wb, flush_wb, valid_mem, wreg_mem;
   logic [1:0]  wb_sel_mem;
   logic [2:0]  load_type_mem;
   logic [1:0]  byte_off_mem;
   logic [31:0] mem_rdata_mem, alu_result_mem, link_pc_mem;
   logic [4:0]  wt_addr_mem;
   logic        wreg_wb, valid_wb, misalign_wb;
   logic [4:0]  wt_addr_wb;
   logic [31:0] wt_data_wb;
   logic [CW-1:0] retired_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state of the WB boundary as seen after each edge.
   logic        m_init = 1'b0;
   logic        m_valid, m_wreg, m_mis;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   int unsigned m_cnt;

   wb_stage_pipe #(.DATA_W(32), .RADDR_W(5), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .stall_wb(stall_wb), .flush_wb(flush_wb),
      .valid_mem(valid_mem), .wreg_mem(wreg_mem), .wb_sel_mem(wb_sel_mem),
      .load_type_mem(load_type_mem), .byte_off_mem(byte_off_mem),
      .mem_rdata_mem(mem_rdata_mem), .alu_result_mem(alu_result_mem),
      .link_pc_mem(link_pc_mem), .wt_addr_mem(wt_addr_mem),
      .wreg_wb(wreg_wb), .wt_addr_wb(wt_addr_wb), .wt_data_wb(wt_data_wb),
      .valid_wb(valid_wb), .misalign_wb(misalign_wb), .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   // Loaded value by arithmetic: shift the lane down, mask, subtract the range when negative.
   function automatic logic [31:0] ref_data(input logic [31:0] rd, input int lt, input int off);
      logic [31:0] b, h;
      b = (rd >> (8 * off)) & 32'h0000_00FF;
      h = (rd >> (16 * (off / 2))) & 32'h0000_FFFF;
      case (lt)
         1:       ref_data = (b >= 32'd128)   ? (b - 32'd256)   : b;
         2:       ref_data = b;
         3:       ref_data = (h >= 32'd32768) ? (h - 32'd65536) : h;
         4:       ref_data = h;
         default: ref_data = rd;
      endcase
   endfunction

   function automatic logic ref_mis(input int lt, input int off);
      case (lt)
         1, 2:    ref_mis = 1'b0;
         3, 4:    ref_mis = (off % 2) != 0;
         default: ref_mis = off != 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_sel(input int sel, input logic [31:0] rd, input int lt,
                                           input int off, input logic [31:0] alu, input logic [31:0] lnk);
      if (sel == 1)      ref_sel = ref_data(rd, lt, off);
      else if (sel == 2) ref_sel = lnk;
      else               ref_sel = alu;
   endfunction

   // Model update on every rising edge.
   always @(posedge clk) begin
      m_init <= 1'b1;
      if (rst) begin
         m_valid <= 1'b0; m_wreg <= 1'b0; m_addr <= 5'd0; m_data <= 32'd0; m_mis <= 1'b0;
         m_cnt   <= 0;
      end else begin
         if (m_valid && !stall_wb) m_cnt <= (m_cnt + 1) % (1 << CW);
         if (flush_wb) begin
            m_valid <= 1'b0; m_wreg <= 1'b0; m_addr <= 5'd0; m_data <= 32'd0; m_mis <= 1'b0;
         end else if (!stall_wb) begin
            m_valid <= valid_mem;
            m_addr  <= wt_addr_mem;
            m_data  <= ref_sel(int'(wb_sel_mem), mem_rdata_mem, int'(load_type_mem),
                               int'(byte_off_mem), alu_result_mem, link_pc_mem);
            m_mis   <= valid_mem && (wb_sel_mem == 2'd1) &&
                       ref_mis(int'(load_type_mem), int'(byte_off_mem));
            m_wreg  <= valid_mem && wreg_mem && (wt_addr_mem != 5'd0) &&
                       !((wb_sel_mem == 2'd1) && ref_mis(int'(load_type_mem), int'(byte_off_mem)));
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (m_init) begin
         chk("valid_wb",    {31'd0, valid_wb},    {31'd0, m_valid});
         chk("wreg_wb",     {31'd0, wreg_wb},     {31'd0, m_wreg});
         chk("misalign_wb", {31'd0, misalign_wb}, {31'd0, m_mis});
         chk("wt_addr_wb",  {27'd0, wt_addr_wb},  {27'd0, m_addr});
         chk("wt_data_wb",  wt_data_wb,           m_data);
         chk("retired_cnt", {28'd0, retired_cnt}, 32'(m_cnt));
      end
   end

   task automatic idle();
      rst = 1'b0; stall_wb = 1'b0; flush_wb = 1'b0; valid_mem = 1'b0; wreg_mem = 1'b0;
      wb_sel_mem = 2'd0; load_type_mem = 3'd0; byte_off_mem = 2'd0;
      mem_rdata_mem = 32'd0; alu_result_mem = 32'd0; link_pc_mem = 32'd0; wt_addr_mem = 5'd0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input int lt, input int off, input logic [4:0] addr);
      idle();
      valid_mem = 1'b1; wreg_mem = 1'b1; wb_sel_mem = 2'd1;
      load_type_mem = 3'(lt); byte_off_mem = 2'(off);
      mem_rdata_mem = 32'h80FF_7F01; wt_addr_mem = addr;
      tick();
   endtask

   initial begin
      idle();
      // Reset for two cycles while MEM claims a valid write.
      rst = 1'b1; valid_mem = 1'b1; wreg_mem = 1'b1; wt_addr_mem = 5'd9; alu_result_mem = 32'hDEAD_BEEF;
      tick(); tick();
      chk("rst_valid", {31'd0, valid_wb}, 32'd0);
      chk("rst_data",  wt_data_wb, 32'd0);
      chk("rst_cnt",   {28'd0, retired_cnt}, 32'd0);

      // ALU write.
      idle(); valid_mem = 1'b1; wreg_mem = 1'b1; alu_result_mem = 32'h1234_5678; wt_addr_mem = 5'd8;
      tick();
      chk("alu_wreg", {31'd0, wreg_wb}, 32'd1);
      chk("alu_addr", {27'd0, wt_addr_wb}, 32'd8);
      chk("alu_data", wt_data_wb, 32'h1234_5678);
      idle(); tick();
      chk("alu_cnt", {28'd0, retired_cnt}, 32'd1);

      // Sub-word loads from 0x80FF_7F01.
      load(1, 3, 5'd3); chk("lb_off3",  wt_data_wb, 32'hFFFF_FF80);
      load(2, 3, 5'd3); chk("lbu_off3", wt_data_wb, 32'h0000_0080);
      load(3, 2, 5'd3); chk("lh_off2",  wt_data_wb, 32'hFFFF_80FF);
      load(4, 0, 5'd3); chk("lhu_off0", wt_data_wb, 32'h0000_7F01);
      load(1, 1, 5'd4); chk("lb_off1",  wt_data_wb, 32'h0000_007F);
      load(3, 1, 5'd3);
      chk("lh_mis_wreg", {31'd0, wreg_wb}, 32'd0);
      chk("lh_mis_flag", {31'd0, misalign_wb}, 32'd1);
      load(0, 0, 5'd0);
      chk("lw_r0_wreg", {31'd0, wreg_wb}, 32'd0);
      chk("lw_r0_mis",  {31'd0, misalign_wb}, 32'd0);
      load(0, 2, 5'd6); chk("lw_mis_flag", {31'd0, misalign_wb}, 32'd1);
      load(7, 0, 5'd6); chk("lt7_word", wt_data_wb, 32'h80FF_7F01);

      // Stall for three cycles while MEM presents different work.
      idle(); valid_mem = 1'b1; wreg_mem = 1'b1; alu_result_mem = 32'hAAAA_5555; wt_addr_mem = 5'd5;
      tick();
      for (int i = 0; i < 3; i++) begin
         idle(); stall_wb = 1'b1; valid_mem = 1'b1; wreg_mem = 1'b1;
         alu_result_mem = 32'(i) + 32'h100; wt_addr_mem = 5'd7;
         tick();
         chk("stall_data", wt_data_wb, 32'hAAAA_5555);
         chk("stall_addr", {27'd0, wt_addr_wb}, 32'd5);
      end
      // Stall and flush together.
      idle(); stall_wb = 1'b1; flush_wb = 1'b1; valid_mem = 1'b1; wreg_mem = 1'b1; wt_addr_mem = 5'd2;
      tick();
      chk("sf_valid", {31'd0, valid_wb}, 32'd0);
      chk("sf_wreg",  {31'd0, wreg_wb}, 32'd0);

      // Link writeback.
      idle(); valid_mem = 1'b1; wreg_mem = 1'b1; wb_sel_mem = 2'd2; link_pc_mem = 32'h0040_0008;
      alu_result_mem = 32'h1111_1111; wt_addr_mem = 5'd31;
      tick();
      chk("link_data", wt_data_wb, 32'h0040_0008);
      // Reserved selector falls back to ALU.
      wb_sel_mem = 2'd3; tick();
      chk("rsvd_data", wt_data_wb, 32'h1111_1111);

      // Reset arriving during a stall.
      idle(); rst = 1'b1; stall_wb = 1'b1; valid_mem = 1'b1;
      tick();
      chk("rst_stall_valid", {31'd0, valid_wb}, 32'd0);
      chk("rst_stall_cnt",   {28'd0, retired_cnt}, 32'd0);

      // Seventeen retirements wrap a 4-bit counter to 1.
      for (int i = 0; i < 17; i++) begin
         idle(); valid_mem = 1'b1; wreg_mem = 1'b1; alu_result_mem = 32'(i * 3); wt_addr_mem = 5'(i + 1);
         tick();
      end
      idle(); tick();
      chk("wrap_cnt", {28'd0, retired_cnt}, 32'd1);
      idle(); tick();
      chk("wrap_hold", {28'd0, retired_cnt}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
